siso_chan_arbiter: RTL and testbench
====================================

# siso_chan_arbiter

Two-requester round-robin arbiter and sequencer for the shared serial shift channel. Accepts parallel words from two requesters over valid/ready handshakes. Loads the granted word into an internal shift register and shifts it out LSB-first, one bit per clock. Sits in front of the serial link so that two producers can share one SISO-style channel without colliding.

## Interface
- WIDTH, default 4: bits per word; legal range WIDTH ≥ 2.
- clk  in  1  rising-edge clock.
- clear_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a word.
- req0_data  in  WIDTH  requester 0 word.
- req0_ready  out  1  requester 0 word accepted this cycle.
- req1_valid  in  1  requester 1 has a word.
- req1_data  in  WIDTH  requester 1 word.
- req1_ready  out  1  requester 1 word accepted this cycle.
- ser_out  out  1  serial data bit.
- ser_valid  out  1  ser_out carries a live bit.
- grant_id  out  1  requester that owns the current frame.
- busy  out  1  frame in progress (state ≠ IDLE).
- done  out  1  one-cycle pulse after the last bit of a frame.

## Operation
- States:
  - IDLE → SHIFT on handshake (reqX_valid && reqX_ready).
  - SHIFT → GAP after bit WIDTH-1.
  - GAP → IDLE unconditionally.
- Grant (combinational, IDLE only):
  - Only one valid: that requester wins.
  - Both valid: the requester ≠ last_grant wins.
  - Neither valid: no grant.
- reqX_ready = (state == IDLE) && (grant == X). At most one ready is high in any cycle. The valid→ready combinational path is intentional.
- On handshake:
  - shreg ← reqX_data.
  - bit counter ← 0.
  - grant_id ← X.
  - last_grant ← X.
- In SHIFT:
  - ser_out = shreg[0]; ser_valid = 1.
  - Each clock: shreg shifts right (zero-fill), counter increments.
  - When the counter reaches WIDTH-1: next state GAP.
- In GAP:
  - done = 1; ser_valid = 0; ready both low.
  - The gap cycle guarantees a visible frame separator.
- Requesters hold valid and data stable until ready. Dropping valid before ready is legal and simply withdraws the request.
- Reset values (asynchronous, immediate):
  - state = IDLE; shreg = 0; counter = 0.
  - ser_out = 0; ser_valid = 0; grant_id = 0; busy = 0; done = 0.
  - last_grant = 1, so requester 0 wins the first contention.
- Reset mid-frame: the partial word is discarded, no done pulse is produced, and the arbiter returns to IDLE.
- Counter width is $clog2(WIDTH). No wrap beyond WIDTH-1 occurs.

## Timing
- Handshake in cycle T. Bit k (k = 0..WIDTH-1) is on ser_out with ser_valid = 1 in cycle T+1+k.
- done is high in cycle T+WIDTH+1 only.
- Next handshake is possible at the earliest in cycle T+WIDTH+2. Peak throughput is one word per WIDTH+2 cycles.
- busy is high in cycles T+1 .. T+WIDTH+1.
- grant_id is stable from T+1 until the next handshake.
- Requests arriving during SHIFT or GAP wait. They are arbitrated in the first IDLE cycle.
- Simultaneous valid rise from both requesters in IDLE: exactly one handshake occurs, per round-robin.

## Structure
- Package siso_chan_pkg:
  - state enum (IDLE, SHIFT, GAP).
  - default WIDTH constant.
- Sub-module rr_arb2:
  - Inputs: two valids, last_grant, enable.
  - Outputs: one-hot grant.
  - Purely combinational.
- Top level holds the FSM, shift register, counter, last_grant and output registers.

## Test plan
- Reset: assert clear_n = 0 mid-cycle. All outputs go 0 immediately. Release, hold both valids low 5 cycles. Outputs stay 0 and no ready is asserted.
- Single word, WIDTH = 4: req0_data = 4'b1010 handshaken at T.
  - ser_out = 0,1,0,1 in T+1..T+4, with ser_valid high.
  - done high only in T+5; grant_id = 0; req0_ready low T+1..T+5.
- Contention: both valid continuously, req0 = 4'h3, req1 = 4'hC.
  - Grants alternate 0,1,0,1.
  - Handshakes spaced exactly 6 cycles apart.
  - Serial streams 1,1,0,0 then 0,0,1,1.
- Same requester back-to-back: only req1 valid, words 4'h5 then 4'h9. Both are granted to requester 1 with a 6-cycle spacing; round-robin does not block a lone requester.
- Reset mid-frame: assert clear_n low after bit 1 of a frame.
  - Outputs clear at once; no done pulse.
  - After release, a fresh req0 word shifts correctly from bit 0.
- Request during frame: req1 raises valid at T+2 of a req0 frame. req1_ready stays low until T+6, then the handshake occurs at T+6.

Source files
------------

// File: rtl/siso_chan_pkg.sv
// Shared types and defaults for the two-requester serial channel arbiter.
package siso_chan_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

endpackage

// File: rtl/siso_chan_arbiter_rr_arb2.sv
// Two-way round-robin grant: on contention the requester that did not win last time gets the channel.
module rr_arb2 (
   input  logic       valid0,
   input  logic       valid1,
   input  logic       last_grant,
   input  logic       enable,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (enable) begin
         if (valid0 && valid1) begin
            grant = last_grant ? 2'b01 : 2'b10;
         end else begin
            grant = {valid1, valid0};
         end
      end
   end

endmodule

// File: rtl/siso_chan_arbiter.sv
// Arbitrates two parallel producers onto one LSB-first serial channel, one frame plus one gap cycle per word.
//   state | meaning
//   IDLE  | channel free, arbitrating requesters
//   SHIFT | driving shreg[0] onto ser_out, one bit per clock
//   GAP   | frame separator, done pulse
module siso_chan_arbiter
   import siso_chan_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req1_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             grant_id,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             grant_id_q, grant_id_d;
   logic             last_grant_q, last_grant_d;
   logic [1:0]       grant;

   rr_arb2 u_rr_arb2 (
      .valid0     (req0_valid),
      .valid1     (req1_valid),
      .last_grant (last_grant_q),
      .enable     (state_q == IDLE),
      .grant      (grant)
   );

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q      <= IDLE;
         shreg_q      <= '0;
         cnt_q        <= '0;
         grant_id_q   <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         cnt_q        <= cnt_d;
         grant_id_q   <= grant_id_d;
         last_grant_q <= last_grant_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      cnt_d        = cnt_q;
      grant_id_d   = grant_id_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (grant[0]) begin
               shreg_d      = req0_data;
               cnt_d        = '0;
               grant_id_d   = 1'b0;
               last_grant_d = 1'b0;
               state_d      = SHIFT;
            end else if (grant[1]) begin
               shreg_d      = req1_data;
               cnt_d        = '0;
               grant_id_d   = 1'b1;
               last_grant_d = 1'b1;
               state_d      = SHIFT;
            end
         end
         SHIFT: begin
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            // Counter parks on the last index rather than wrapping.
            if (cnt_q == CNT_LAST) begin
               state_d = GAP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign ser_valid = (state_q == SHIFT);
   assign ser_out   = ser_valid & shreg_q[0];
   assign done      = (state_q == GAP);
   assign busy      = (state_q != IDLE);
   assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_siso_chan_arbiter.sv
// Self-checking bench for siso_chan_arbiter against a frame-timing reference model.
module tb_siso_chan_arbiter;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         clear_n = 1'b1;
   logic         req0_valid = 1'b0;
   logic         req1_valid = 1'b0;
   logic [W-1:0] req0_data = '0;
   logic [W-1:0] req1_data = '0;
   logic         req0_ready, req1_ready, ser_out, ser_valid, grant_id, busy, done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   siso_chan_arbiter #(.WIDTH(W)) dut (
      .clk        (clk),
      .clear_n    (clear_n),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .ser_out    (ser_out),
      .ser_valid  (ser_valid),
      .grant_id   (grant_id),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // bit order: req0_ready req1_ready ser_out ser_valid grant_id busy done
   wire [6:0] obs = {req0_ready, req1_ready, ser_out, ser_valid, grant_id, busy, done};

   // Reference model: a frame is described only by its handshake cycle, word and owner.
   int           m_t;
   logic [W-1:0] m_word;
   logic         m_id, m_last;
   logic [6:0]   exp_v;
   logic         hs_seen, hs_id;

   function automatic void model_reset();
      m_t    = -100;
      m_word = '0;
      m_id   = 1'b0;
      m_last = 1'b1;
   endfunction

   function automatic void model_step();
      bit idle, gv, g, sv, so, dn, bz;
      idle = (cyc >= m_t + W + 2);
      gv   = idle && (req0_valid || req1_valid);
      g    = (req0_valid && req1_valid) ? !m_last : req1_valid;
      sv   = (cyc >= m_t + 1) && (cyc <= m_t + W);
      so   = 1'b0;
      if (sv) so = m_word[cyc - m_t - 1];
      dn   = (cyc == m_t + W + 1);
      bz   = (cyc >= m_t + 1) && (cyc <= m_t + W + 1);
      exp_v   = {gv && !g, gv && g, so, sv, m_id, bz, dn};
      hs_seen = gv;
      hs_id   = g;
      if (gv) begin
         m_t    = cyc;
         m_word = g ? req1_data : req0_data;
         m_id   = g;
         m_last = g;
      end
   endfunction

   task automatic test_reset();
      #2 clear_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (obs !== 7'b0) begin
         errors++;
         $display("FAIL reset_immediate got=%b exp=%b", obs, 7'b0);
      end
      repeat (2) @(posedge clk);
      #2 clear_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         req0_valid = 1'b0; req1_valid = 1'b0;
         @(negedge clk); model_step();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
         end
      end
   endtask

   task automatic test_single_word();
      logic [W-1:0] bits = '0;
      for (int i = 0; i < W + 4; i++) begin
         @(posedge clk); #1;
         req0_valid = (i == 0); req0_data = 4'b1010;
         @(negedge clk); model_step();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL single_word cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
         end
         if (ser_valid) bits = {ser_out, bits[W-1:1]};
      end
      checks++;
      if (bits !== 4'b1010) begin
         errors++;
         $display("FAIL single_word_stream got=%b exp=%b", bits, 4'b1010);
      end
   endtask

   task automatic test_contention();
      int   hs_t[$];
      logic hs_g[$];
      for (int i = 0; i < 24; i++) begin
         @(posedge clk); #1;
         req0_valid = 1'b1; req1_valid = 1'b1;
         req0_data = 4'h3; req1_data = 4'hC;
         @(negedge clk); model_step();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL contention cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
         end
         if (req0_ready || req1_ready) begin
            hs_t.push_back(i);
            hs_g.push_back(req1_ready);
         end
      end
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk); model_step();
      checks++;
      if (hs_t.size() != 4) begin
         errors++;
         $display("FAIL contention_count got=%0d exp=%0d", hs_t.size(), 4);
      end
      for (int k = 1; k < hs_t.size(); k++) begin
         checks++;
         if (hs_t[k] - hs_t[k-1] != W + 2 || hs_g[k] == hs_g[k-1]) begin
            errors++;
            $display("FAIL contention_spacing k=%0d got=%0d/%b exp=%0d/%b",
                     k, hs_t[k] - hs_t[k-1], hs_g[k], W + 2, !hs_g[k-1]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int n_hs = 0;
      int first = 0;
      int second = 0;
      for (int i = 0; i < 14; i++) begin
         @(posedge clk); #1;
         req1_valid = (n_hs < 2);
         req1_data  = (n_hs == 0) ? 4'h5 : 4'h9;
         @(negedge clk); model_step();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
         end
         if (req1_ready) begin
            if (n_hs == 0) first = i; else second = i;
            n_hs++;
         end
      end
      checks++;
      if (n_hs != 2 || second - first != W + 2) begin
         errors++;
         $display("FAIL back_to_back_spacing got=%0d hs, %0d cycles exp=2 hs, %0d cycles",
                  n_hs, second - first, W + 2);
      end
   endtask

   task automatic test_request_during_frame();
      int  first_rdy = -1;
      bit  served = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         req0_valid = (i == 0); req0_data = 4'($urandom);
         req1_valid = (i >= 2) && !served; req1_data = 4'h6;
         @(negedge clk); model_step();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL during_frame cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
         end
         if (req1_ready && first_rdy < 0) first_rdy = i;
         if (req1_ready) served = 1'b1;
      end
      checks++;
      if (first_rdy != W + 2) begin
         errors++;
         $display("FAIL during_frame_wait got=%0d exp=%0d", first_rdy, W + 2);
      end
   endtask

   task automatic test_reset_mid_frame();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         req0_valid = (i == 0); req0_data = 4'b1101;
         @(negedge clk); model_step();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL mid_reset_pre cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
         end
      end
      @(posedge clk);
      #2 clear_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (obs !== 7'b0) begin
         errors++;
         $display("FAIL mid_reset_clear got=%b exp=%b", obs, 7'b0);
      end
      @(posedge clk);
      #2 clear_n = 1'b1;
      for (int i = 0; i < W + 8; i++) begin
         @(posedge clk); #1;
         req0_valid = (i == 4); req0_data = 4'b0110;
         req1_valid = (i == 4); req1_data = 4'b1001;
         @(negedge clk); model_step();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL mid_reset_post cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
         end
      end
   endtask

   task automatic test_random();
      bit drop0 = 1'b0;
      bit drop1 = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (drop0) req0_valid = 1'b0;
         if (drop1) req1_valid = 1'b0;
         if (!req0_valid) begin
            req0_valid = ($urandom_range(0, 2) == 0);
            req0_data  = 4'($urandom);
         end else if ($urandom_range(0, 9) == 0) begin
            req0_valid = 1'b0;
         end
         if (!req1_valid) begin
            req1_valid = ($urandom_range(0, 2) == 0);
            req1_data  = 4'($urandom);
         end else if ($urandom_range(0, 9) == 0) begin
            req1_valid = 1'b0;
         end
         @(negedge clk); model_step();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
         end
         drop0 = hs_seen && !hs_id;
         drop1 = hs_seen && hs_id;
      end
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_word();
      test_contention();
      test_back_to_back();
      test_request_during_frame();
      test_reset_mid_frame();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
